// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and defaults for the FIFO-draining UART transmitter.
package uart_pkg;
  localparam int   DATA_WIDTH_DEF   = 8;
  localparam int   CLKS_PER_BIT_DEF = 434;
  localparam logic IDLE_LEVEL       = 1'b1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake of the width-converting FIFO (show-ahead head byte + pop strobe).
interface fifo_uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic                  empty;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  rd;

  modport master (output empty, output r_data, input rd);
  modport slave  (input empty, input r_data, output rd);
endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, tick on terminal count, clear forces 0.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int            CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == TC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              r_cnt <= '0;
    else if (clear || tick)  r_cnt <= '0;
    else                     r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the FIFO and serialises them LSB first, 8N1, frames back-to-back.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  fifo_uart_tx_if.slave        fifo,
  output logic                 tx,
  output logic                 busy
);
  localparam int            IDX_MAX   = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int            IW        = (IDX_MAX > 2) ? $clog2(IDX_MAX) : 1;
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  tx_state_t             r_state, w_state;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic [IW-1:0]         r_idx,   w_idx;
  logic                  r_tx,    w_tx;
  logic                  w_tick, w_clear, w_last_stop, w_rd;
`ifdef UART_TX_PARITY_EN
  logic                  r_par,   w_par;
`endif

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .tick  (w_tick)
  );

  // Pop decision points: idle, or the final cycle of the last stop bit.
  // Gated by reset so nothing is popped while the block is held in reset.
  assign w_last_stop = (r_state == STOP) && w_tick && (r_idx == STOP_LAST);
  assign w_rd        = reset && enable && !fifo.empty &&
                       ((r_state == IDLE) || w_last_stop);
  assign w_clear     = w_rd || (r_state == IDLE);

  assign fifo.rd = w_rd;
  assign tx      = r_tx;
  assign busy    = (r_state != IDLE);

  always_comb begin
    w_state = r_state;
    w_shift = r_shift;
    w_idx   = r_idx;
    w_tx    = r_tx;
`ifdef UART_TX_PARITY_EN
    w_par   = r_par;
`endif
    if (w_rd) begin
      w_state = START;
      w_shift = fifo.r_data;
      w_idx   = '0;
      w_tx    = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par   = ^fifo.r_data;
`endif
    end else begin
      case (r_state)
        IDLE: w_tx = IDLE_LEVEL;
        START: if (w_tick) begin
          w_state = DATA;
          w_tx    = r_shift[0];
        end
        DATA: if (w_tick) begin
          if (r_idx == DATA_LAST) begin
            w_idx = '0;
`ifdef UART_TX_PARITY_EN
            w_state = PARITY;
            w_tx    = r_par;
`else
            w_state = STOP;
            w_tx    = IDLE_LEVEL;
`endif
          end else begin
            w_idx   = r_idx + 1'b1;
            w_shift = r_shift >> 1;
            w_tx    = w_shift[0];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (w_tick) begin
          w_state = STOP;
          w_tx    = IDLE_LEVEL;
        end
`endif
        STOP: if (w_tick) begin
          if (r_idx == STOP_LAST) w_state = IDLE;
          else                    w_idx   = r_idx + 1'b1;
        end
        default: begin
          w_state = IDLE;
          w_tx    = IDLE_LEVEL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_idx   <= w_idx;
      r_tx    <= w_tx;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the byte-wide read side of the team's width-converting FIFO (16-bit write, 8-bit read). It pops one byte at a time from the FIFO and serialises it onto a UART line: 8N1 by default, LSB first. Frames go out back-to-back with no idle gap while the FIFO holds data. This is the drain stage that turns buffered bytes into the board's serial output.

Parameters:
DATA_WIDTH, 8, byte width popped from FIFO; must match the FIFO read width
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); minimum 2
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
enable  input  1  permit starting new frames; a frame in flight always completes
empty  input  1  FIFO empty flag
r_data  input  DATA_WIDTH  FIFO head byte; valid whenever empty=0 (show-ahead)
rd  output  1  FIFO pop strobe; one-cycle pulse per byte
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress

Behaviour:
- Reset (reset=0, async): tx=1, rd=0, busy=0, state=IDLE, baud counter=0, bit index=0, shift register=0. tx must go high immediately, not on the next edge.
- States: IDLE, START, DATA, STOP (plus PARITY when the optional feature is built in).
- rd is combinational from registered state plus inputs:
  - rd = enable & ~empty & (state==IDLE | last cycle of STOP).
  - rd is never high while empty=1.
  - In the rd cycle, r_data is loaded into the shift register and the next state is START with baud counter 0.
- tx is registered:
  - Start bit (0) appears on the edge after the rd cycle, so pop-to-line latency is 1 cycle.
- Each bit lasts exactly CLKS_PER_BIT cycles:
  - The baud counter counts 0..CLKS_PER_BIT-1.
  - A bit advances on terminal count.
- DATA: DATA_WIDTH bits, LSB first. Bit index runs 0..DATA_WIDTH-1; after the last bit go to STOP (or PARITY).
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle:
  - if enable & ~empty: pop and go to START, giving a back-to-back frame with no idle cycle;
  - otherwise go to IDLE.
- Frame length = (1 + DATA_WIDTH + STOP_BITS) * CLKS_PER_BIT cycles.
- busy = (state != IDLE).
- enable deasserted mid-frame: current frame finishes normally, then IDLE; no further rd.
- empty rising mid-frame: no effect until the next pop decision point.
- Reset mid-frame: the frame is abandoned. After release, the block waits in IDLE and pops the next byte normally; the aborted byte is lost.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP and sends one even-parity bit (XOR of data bits) for CLKS_PER_BIT cycles. Frame = (2 + DATA_WIDTH + STOP_BITS) * CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic, plain 8N1 framing.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - the localparam defaults for CLKS_PER_BIT and DATA_WIDTH;
  - the IDLE_LEVEL=1'b1 constant.
- One sub-module, uart_baud_counter:
  - inputs: clk, reset, clear;
  - output: tick (terminal count), parameterised by CLKS_PER_BIT;
  - same async active-low reset.
- The state machine, shift register and bit index stay in fifo_uart_tx.

Test Plan:
- Single byte (CLKS_PER_BIT=4): empty=0, r_data=0xA5, enable=1 → exactly one rd pulse. tx reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles), then tx=1, busy=0.
- Back-to-back bytes: FIFO supplies 0x01 then 0x80 → 80 contiguous cycles of framing with no idle gap. rd pulses exactly twice, the second on the last stop cycle of frame 1.
- Empty FIFO: empty=1 for 200 cycles with enable=1 → rd never asserted, tx=1, busy=0 throughout.
- Enable drop: enable→0 during data bit 3 of byte 0x3C while empty=0 → frame completes (stop bit high), then IDLE with no further rd.
- Reset mid-frame: reset=0 during data bit 5 → tx=1 and rd=0 in the same cycle. After release with empty=0, the next frame starts with a start bit one cycle after its rd.
- With UART_TX_PARITY_EN: byte 0x07 → parity bit 1 between data and stop; frame length 44 cycles at CLKS_PER_BIT=4.
